// File: rtl/bp_btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
// Imported by the BTB top and its counter helper.
package bp_btb_predictor_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int WORD_WIDTH = 32;

  typedef enum logic {
    BTB_INIT = 1'b0,
    BTB_RUN  = 1'b1
  } btb_state_e;

endpackage

// File: rtl/bp_btb_predictor_sat_counter_next.sv
// Next value of a saturating up/down counter.
// Holds at all-ones going up and at zero going down.
module bp_btb_predictor_sat_counter_next
  import bp_btb_predictor_pkg::*;
#(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cnt,
  input  logic                up,
  output logic [CNT_BITS-1:0] next
);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

  logic at_max;
  logic at_zero;

  assign at_max  = (cnt == CNT_MAX);
  assign at_zero = (cnt == CNT_ZERO);

  always_comb begin
    next = cnt;
    unique case (1'b1)
      up && !at_max:   next = cnt + 1'b1;
      !up && !at_zero: next = cnt - 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bp_btb_predictor.sv
// Direct-mapped BTB with saturating counters and an
// init/invalidate sweep so storage fits a 1-write-port RAM.
module bp_btb_predictor
  import bp_btb_predictor_pkg::*;
#(
  parameter int W        = WORD_WIDTH,
  parameter int ENTRIES  = 64,
  parameter int CNT_BITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_all,
  input  logic [W-1:0] lookup_pc,
  output logic         predict_j_taken,
  output logic [W-1:0] predict_addr,
  output logic         ready,
  input  logic         upd,
  input  logic         add_else_minus,
  input  logic [W-1:0] upd_src_pc,
  input  logic [W-1:0] upd_targ
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = W - 2 - IDX_BITS;

  localparam logic [IDX_BITS-1:0] IDX_LAST =
    IDX_BITS'(ENTRIES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ALLOC =
    CNT_BITS'(1 << (CNT_BITS - 1));

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [W-1:0]        targ_q  [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q   [ENTRIES];

  btb_state_e          state_q;
  logic [IDX_BITS-1:0] init_idx_q;

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic                up_go;
  logic [CNT_BITS-1:0] cnt_nxt;

  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic                wr_valid;
  logic [CNT_BITS-1:0] wr_cnt;
  logic                wr_tag_en;
  logic                wr_targ_en;

  logic                unused_lsbs;

  assign unused_lsbs = ^{lookup_pc[1:0], upd_src_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_BITS+1:2];
  assign lk_tag = lookup_pc[W-1:IDX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign ready = (state_q == BTB_RUN);

  assign predict_j_taken =
    ready && lk_hit && cnt_q[lk_idx][CNT_BITS-1];

  assign predict_addr = predict_j_taken ?
    targ_q[lk_idx] : lookup_pc + W'(4);

  assign up_idx = upd_src_pc[IDX_BITS+1:2];
  assign up_tag = upd_src_pc[W-1:IDX_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // a flush in the same cycle wins over the update
  assign up_go = ready && upd && !flush_all;

  bp_btb_predictor_sat_counter_next #(
    .CNT_BITS(CNT_BITS)
  ) u_cnt_next (
    .cnt (cnt_q[up_idx]),
    .up  (add_else_minus),
    .next(cnt_nxt)
  );

  always_comb begin
    wr_en      = FALSE;
    wr_idx     = up_idx;
    wr_valid   = TRUE;
    wr_cnt     = cnt_nxt;
    wr_tag_en  = FALSE;
    wr_targ_en = FALSE;
    unique case (1'b1)
      !ready: begin
        wr_en    = TRUE;
        wr_idx   = init_idx_q;
        wr_valid = FALSE;
        wr_cnt   = '0;
      end
      up_go && add_else_minus: begin
        wr_en      = TRUE;
        wr_targ_en = TRUE;
        wr_tag_en  = !up_hit;
        wr_cnt     = up_hit ? cnt_nxt : CNT_ALLOC;
      end
      up_go && !add_else_minus && up_hit: begin
        wr_en = TRUE;
      end
      default: ;
    endcase
  end

  // storage has no reset; the sweep clears valid and cnt
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      valid_q[wr_idx] <= wr_valid;
      cnt_q[wr_idx]   <= wr_cnt;
      if (wr_tag_en) begin
        tag_q[wr_idx] <= up_tag;
      end
      if (wr_targ_en) begin
        targ_q[wr_idx] <= upd_targ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BTB_INIT;
      init_idx_q <= '0;
    end else begin
      unique case (state_q)
        BTB_INIT: begin
          if (flush_all) begin
            init_idx_q <= '0;
          end else begin
            init_idx_q <= init_idx_q + 1'b1;
            if (init_idx_q == IDX_LAST) begin
              state_q <= BTB_RUN;
            end
          end
        end
        BTB_RUN: begin
          if (flush_all) begin
            state_q    <= BTB_INIT;
            init_idx_q <= '0;
          end
        end
        default: begin
          state_q    <= BTB_INIT;
          init_idx_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_btb_predictor.sv
// Bench for bp_btb_predictor: directed vector table,
// sweep/flush sequences and a randomized reference model.
module tb_bp_btb_predictor;

  localparam int NENT  = 64;
  localparam int CBITS = 2;
  localparam int CMAX  = (1 << CBITS) - 1;
  localparam int CALOC = 1 << (CBITS - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_all;
  logic [31:0] lookup_pc;
  logic        predict_j_taken;
  logic [31:0] predict_addr;
  logic        ready;
  logic        upd;
  logic        add_else_minus;
  logic [31:0] upd_src_pc;
  logic [31:0] upd_targ;

  int checks = 0;
  int errors = 0;

  bp_btb_predictor #(
    .W(32),
    .ENTRIES(NENT),
    .CNT_BITS(CBITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_all(flush_all),
    .lookup_pc(lookup_pc),
    .predict_j_taken(predict_j_taken),
    .predict_addr(predict_addr),
    .ready(ready),
    .upd(upd),
    .add_else_minus(add_else_minus),
    .upd_src_pc(upd_src_pc),
    .upd_targ(upd_targ)
  );

  always #5 clk = ~clk;

  // reference model: plain per-index records
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  int unsigned m_targ  [NENT];
  int          m_cnt   [NENT];

  typedef struct {
    bit          u;
    bit          t;
    logic [31:0] upc;
    logic [31:0] targ;
    logic [31:0] lpc;
    bit          exp_t;
    logic [31:0] exp_a;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_clear();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 0;
    end
  endfunction

  function automatic void m_update(bit u, bit t,
                                   int unsigned pc,
                                   int unsigned targ);
    int          i;
    int unsigned tg;
    bit          hit;
    i   = int'((pc / 4) % NENT);
    tg  = pc / (4 * NENT);
    hit = m_valid[i] && (m_tag[i] == tg);
    if (!u) return;
    if (t) begin
      if (hit) begin
        m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tg;
        m_cnt[i]   = CALOC;
      end
      m_targ[i] = targ;
    end else if (hit) begin
      m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
    end
  endfunction

  function automatic void m_predict(int unsigned pc,
                                    output bit tk,
                                    output logic [31:0] a);
    int i;
    i  = int'((pc / 4) % NENT);
    tk = m_valid[i] && (m_tag[i] == pc / (4 * NENT))
         && (m_cnt[i] >= CALOC);
    a  = tk ? m_targ[i] : pc + 4;
  endfunction

  function automatic vec_t mk(bit u, bit t,
                              logic [31:0] upc,
                              logic [31:0] targ,
                              logic [31:0] lpc,
                              bit et, logic [31:0] ea);
    vec_t v;
    v.u = u; v.t = t; v.upc = upc; v.targ = targ;
    v.lpc = lpc; v.exp_t = et; v.exp_a = ea;
    return v;
  endfunction

  task automatic idle_inputs();
    flush_all      = 1'b0;
    upd            = 1'b0;
    add_else_minus = 1'b0;
    upd_src_pc     = 32'h0;
    upd_targ       = 32'h0;
  endtask

  // n cycles of sweep: not ready, no taken prediction
  task automatic sweep_chk(input string name, input int n);
    lookup_pc = 32'h80;
    for (int c = 0; c < n; c++) begin
      #1;
      chk({name, "_rdy"}, 32'(ready), 32'd0);
      chk({name, "_tk"}, 32'(predict_j_taken), 32'd0);
      chk({name, "_addr"}, predict_addr, 32'h84);
      tick();
    end
  endtask

  initial begin
    bit          etk;
    logic [31:0] ea;
    int unsigned pc;
    int unsigned lp;

    // u  t  upc   targ   lpc    exp_t exp_addr
    vt.push_back(mk(1, 1, 32'h40, 32'h200, 32'h40, 0, 32'h44));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h40, 1, 32'h200));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, 32'h40, 1, 32'h200));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, 32'h40, 0, 32'h44));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, 32'h40, 0, 32'h44));
    vt.push_back(mk(1, 1, 32'h40, 32'h200, 32'h40, 0, 32'h44));
    vt.push_back(mk(1, 1, 32'h40, 32'h200, 32'h40, 0, 32'h44));
    vt.push_back(mk(1, 1, 32'h40, 32'h200, 32'h40, 1, 32'h200));
    vt.push_back(mk(1, 1, 32'h40, 32'h200, 32'h40, 1, 32'h200));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, 32'h40, 1, 32'h200));
    vt.push_back(mk(1, 0, 32'h40, 32'h0, 32'h40, 1, 32'h200));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h40, 0, 32'h44));
    vt.push_back(mk(1, 1, 32'h40, 32'h300, 32'h140, 0, 32'h144));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h40, 1, 32'h300));
    vt.push_back(mk(1, 1, 32'h140, 32'h400, 32'h40, 1, 32'h300));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h40, 0, 32'h44));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h140, 1, 32'h400));
    vt.push_back(mk(1, 1, 32'h80, 32'h500, 32'h80, 0, 32'h84));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h80, 1, 32'h500));
    vt.push_back(mk(1, 0, 32'h1080, 32'h0, 32'h80, 1, 32'h500));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h80, 1, 32'h500));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'h82, 1, 32'h500));
    vt.push_back(mk(0, 0, 32'h0, 32'h0, 32'hFFFFFFFC, 0, 32'h0));

    rst = 1'b1;
    idle_inputs();
    lookup_pc = 32'h100;
    m_clear();
    tick();
    tick();
    chk("rst_rdy", 32'(ready), 32'd0);
    chk("rst_tk", 32'(predict_j_taken), 32'd0);
    chk("rst_addr", predict_addr, 32'h104);

    rst = 1'b0;
    for (int c = 0; c < NENT; c++) begin
      #1;
      chk("init_rdy", 32'(ready), 32'd0);
      chk("init_tk", 32'(predict_j_taken), 32'd0);
      chk("init_addr", predict_addr, 32'h104);
      tick();
    end
    chk("init_done", 32'(ready), 32'd1);
    chk("init_miss", 32'(predict_j_taken), 32'd0);

    foreach (vt[k]) begin
      upd            = vt[k].u;
      add_else_minus = vt[k].t;
      upd_src_pc     = vt[k].upc;
      upd_targ       = vt[k].targ;
      lookup_pc      = vt[k].lpc;
      #1;
      chk($sformatf("vec%0d_tk", k),
          32'(predict_j_taken), 32'(vt[k].exp_t));
      chk($sformatf("vec%0d_addr", k), predict_addr, vt[k].exp_a);
      m_update(vt[k].u, vt[k].t, vt[k].upc, vt[k].targ);
      tick();
    end
    idle_inputs();

    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 3) << 8) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      lp = ($urandom_range(0, 3) << 8) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd            = 1'($urandom_range(0, 1));
      add_else_minus = 1'($urandom_range(0, 1));
      upd_src_pc     = pc;
      upd_targ       = $urandom & 32'hFFFFFFFC;
      lookup_pc      = lp;
      #1;
      m_predict(lp, etk, ea);
      chk("rnd_tk", 32'(predict_j_taken), 32'(etk));
      chk("rnd_addr", predict_addr, ea);
      m_update(upd, add_else_minus, upd_src_pc, upd_targ);
      tick();
    end
    idle_inputs();

    // flush in RUN with a concurrent update that must be dropped
    lookup_pc      = 32'h80;
    flush_all      = 1'b1;
    upd            = 1'b1;
    add_else_minus = 1'b1;
    upd_src_pc     = 32'h40;
    upd_targ       = 32'h600;
    #1;
    chk("fl_pre_tk", 32'(predict_j_taken), 32'd1);
    chk("fl_pre_addr", predict_addr, 32'h500);
    tick();
    idle_inputs();
    sweep_chk("fl_a", 40);
    flush_all = 1'b1;
    tick();
    flush_all = 1'b0;
    sweep_chk("fl_b", NENT);
    chk("fl_done", 32'(ready), 32'd1);
    m_clear();

    foreach (vt[k]) begin
      lookup_pc = vt[k].lpc;
      #1;
      m_predict(vt[k].lpc, etk, ea);
      chk("post_fl_tk", 32'(predict_j_taken), 32'(etk));
      chk("post_fl_addr", predict_addr, ea);
      tick();
    end

    // rst mid-sweep restarts the full sweep
    flush_all = 1'b1;
    tick();
    flush_all = 1'b0;
    sweep_chk("rs_a", 25);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_chk("rs_b", NENT);
    chk("rs_done", 32'(ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d want done", checks);
    $fatal(1, "timeout");
  end

endmodule
